// File: rtl/pipe_sched_ctrl_pkg.sv
// Shared constants for the pipeline scheduler:
// stall vector layout, FSM encodings and reset polarity.
package pipe_sched_ctrl_pkg;

    localparam int STALL_PC_BIT  = 0;
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_ID_BIT  = 2;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [4:0] NOPRegAddr = 5'd0;
    localparam logic       RstEnable  = 1'b0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_e;

endpackage

// File: rtl/sched_scoreboard.sv
// Per-register write-pending counters with issue/decrement
// and two combinational pending-read ports.
module sched_scoreboard
    import pipe_sched_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LAT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_wd_i,
    input  logic [LAT_W-1:0]  issue_lat_i,
    input  logic              dec_en_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic              rd1_pend_o,
    output logic              rd2_pend_o
);

    logic [LAT_W-1:0] cnt [NUM_REGS];

    // A new issue overrides any decrement on the same entry.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue_i && issue_wd_i == ADDR_W'(r)) begin
                    cnt[r] <= issue_lat_i;
                end else if (dec_en_i && cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    assign rd1_pend_o = (cnt[rd1_addr_i] != '0);
    assign rd2_pend_o = (cnt[rd2_addr_i] != '0);

endmodule

// File: rtl/pipe_sched_ctrl.sv
// Pipeline scheduler: hazard stall, EX-busy stall,
// one-cycle flush with redirect PC and stall-cycle counter.
module pipe_sched_ctrl
    import pipe_sched_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LAT_W    = 2,
    parameter int PC_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic              id_reg1_read_i,
    input  logic [ADDR_W-1:0] id_reg1_addr_i,
    input  logic              id_reg2_read_i,
    input  logic [ADDR_W-1:0] id_reg2_addr_i,
    input  logic              id_wreg_i,
    input  logic [ADDR_W-1:0] id_wd_i,
    input  logic [LAT_W-1:0]  id_lat_i,
    input  logic              ex_busy_i,
    input  logic              flush_req_i,
    input  logic [PC_W-1:0]   flush_pc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic [PC_W-1:0]   new_pc_o,
    output logic [31:0]       stall_cnt_o
);

    sched_state_e state, state_nxt;
    logic flush_nxt;
    logic pend1, pend2;
    logic hazard, accept, issue;

    assign hazard = id_valid_i &&
        ((id_reg1_read_i && id_reg1_addr_i != ADDR_W'(NOPRegAddr) && pend1) ||
         (id_reg2_read_i && id_reg2_addr_i != ADDR_W'(NOPRegAddr) && pend2));

    always_comb begin
        stall_o = STALL_NONE;
        if (state == FLUSH) begin
            stall_o = STALL_NONE;
        end else if (ex_busy_i) begin
            stall_o = STALL_EX;
        end else if (hazard) begin
            stall_o = STALL_ID;
        end
    end

    assign accept = id_valid_i && !stall_o[STALL_ID_BIT] &&
                    state != FLUSH && !flush_req_i;
    assign issue  = accept && id_wreg_i &&
                    id_wd_i != ADDR_W'(NOPRegAddr) && id_lat_i != '0;

    sched_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .LAT_W    (LAT_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue),
        .issue_wd_i  (id_wd_i),
        .issue_lat_i (id_lat_i),
        .dec_en_i    (!stall_o[STALL_EX_BIT]),
        .rd1_addr_i  (id_reg1_addr_i),
        .rd2_addr_i  (id_reg2_addr_i),
        .rd1_pend_o  (pend1),
        .rd2_pend_o  (pend2)
    );

    // Requests arriving while already flushing are dropped.
    always_comb begin
        state_nxt = state;
        flush_nxt = 1'b0;
        unique case (state)
            RUN: begin
                if (flush_req_i) begin
                    state_nxt = FLUSH;
                    flush_nxt = 1'b1;
                end
            end
            FLUSH: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state       <= RUN;
            flush_o     <= 1'b0;
            new_pc_o    <= '0;
            stall_cnt_o <= '0;
        end else begin
            state   <= state_nxt;
            flush_o <= flush_nxt;
            if (flush_nxt) begin
                new_pc_o <= flush_pc_i;
            end
            if (stall_o != STALL_NONE && stall_cnt_o != 32'hFFFF_FFFF) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: doc/pipe_sched_ctrl.md
Name: pipe_sched_ctrl

Overview:
- Pipeline scheduler for the 5-stage core. Owns a per-register write-pending scoreboard for results that the decode-stage forwarding (EX/MEM bypass) cannot cover yet, e.g. loads and multi-cycle ops.
- Generates the stage stall vector and a one-cycle flush with redirect PC.
- Sits beside the decode stage: decode reports operand reads and issued destinations; EX reports multi-cycle busy; branch/exception logic requests flushes.

Parameters:
- NUM_REGS, 32, architectural register count; r0 is never pending.
- ADDR_W, 5, register address width.
- LAT_W, 2, pending-latency counter width; max latency is 2^LAT_W-1.
- PC_W, 32, instruction address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  decode holds a valid instruction.
- id_reg1_read_i  in  1  operand 1 read from regfile.
- id_reg1_addr_i  in  ADDR_W  operand 1 address.
- id_reg2_read_i  in  1  operand 2 read from regfile.
- id_reg2_addr_i  in  ADDR_W  operand 2 address.
- id_wreg_i  in  1  decoded instruction writes a register.
- id_wd_i  in  ADDR_W  destination register.
- id_lat_i  in  LAT_W  cycles until the result is forwardable; 0 means the normal EX bypass covers it.
- ex_busy_i  in  1  EX is running a multi-cycle op.
- flush_req_i  in  1  redirect request.
- flush_pc_i  in  PC_W  redirect target.
- stall_o  out  6  stall[0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.
- flush_o  out  1  registered one-cycle flush pulse.
- new_pc_o  out  PC_W  redirect PC, valid while flush_o=1.
- stall_cnt_o  out  32  saturating count of cycles with stall_o!=0.

Behaviour:
- Reset (rst=0, async): all scoreboard counters=0, state=RUN, stall_o=0, flush_o=0, new_pc_o=0, stall_cnt_o=0.
- Scoreboard: one LAT_W counter per register.
  - Entry r is pending when cnt[r]!=0.
  - cnt[0] is hardwired to 0.
- Hazard (combinational): id_valid_i AND ((reg1_read AND addr1!=0 AND cnt[addr1]!=0) OR the same test on operand 2).
- stall_o (combinational, from state and inputs), priority top-down:
  - state FLUSH: 6'b000000.
  - ex_busy_i: 6'b001111.
  - hazard: 6'b000111.
  - otherwise: 0.
- Issue: accepted when id_valid_i AND stall_o[2]=0 AND state!=FLUSH AND flush_req_i=0.
  - On acceptance with id_wreg_i=1, id_wd_i!=0 and id_lat_i!=0: cnt[id_wd_i] <= id_lat_i next edge.
- Decrement: every edge with stall_o[3]=0, every nonzero counter decrements by 1.
  - When the issue target coincides with a decrementing entry, the issue value wins (no decrement applied).
  - With stall_o[3]=1, counters hold.
- FSM states:
  - RUN to FLUSH on flush_req_i. Capture new_pc_o<=flush_pc_i and set flush_o<=1.
  - FLUSH to RUN unconditionally after 1 cycle; flush_o clears.
  - flush_req_i while in FLUSH is ignored.
  - flush_req_i in the same cycle as a hazard: the flush wins. The instruction is not issued and the stall is still driven that cycle (the state is still RUN).
- Scoreboard is NOT cleared on flush: older in-flight writers remain valid.
- stall_cnt_o increments on every edge where stall_o!=0 and saturates at 32'hFFFFFFFF.
- Latency: hazard-to-stall is 0 cycles (combinational). Issue-to-pending is 1 edge. A load with lat=1 stalls a back-to-back dependent instruction exactly 1 cycle.

Decomposition:
- Shared defines file:
  - stall vector bit positions and patterns STALL_NONE/STALL_ID/STALL_EX;
  - FSM state encodings RUN/FLUSH;
  - NOPRegAddr and the RstEnable polarity constant for active-low reset.
- Sub-module sched_scoreboard holds the counter array, issue/decrement logic and two combinational pending-read ports. The top holds the FSM, stall mux and stall counter.

Test Plan:
- Load then use: issue wd=3 lat=1, next cycle read r3 -> stall_o=000111 for exactly 1 cycle, then 0; stall_cnt_o=1.
- ALU then use: issue wd=3 lat=0, next read r3 -> no stall; cnt[3] stays 0.
- r0 write: issue wd=0 lat=3, then read r0 -> never stalls.
- EX busy over hazard: ex_busy_i=1 for 4 cycles with a pending lat=2 entry -> stall_o=001111 for 4 cycles, counter holds at 2, then hazard stall for 2 cycles.
- Flush: flush_req_i=1, flush_pc_i=32'h0000_0100 during a hazard -> next cycle flush_o=1, new_pc_o=32'h100, stall_o=0; the pending entry still decrements to 0.
- Async reset mid-stall: rst=0 between edges -> all outputs 0 immediately, scoreboard cleared, state=RUN.
